ecc_op_sequencer: RTL and testbench

- Parametrised successor to the ECC accelerator's CV-X-IF control FSM.
- Accepts decoded issue requests and holds the modulus register.
- Dispatches modular ADD/SUB/MUL to external arithmetic units and supervises each with a timeout.
- Queues results in a RES_DEPTH-entry buffer with full valid/ready backpressure toward the core result interface.

---
 rtl/ecc_acc_pkg.sv | 35 +++
 rtl/ecc_op_sequencer_if.sv | 40 ++++
 rtl/ecc_result_fifo.sv | 60 ++++++
 rtl/ecc_op_sequencer.sv | 155 +++++++++++++++
 tb/tb_ecc_op_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_acc_pkg.sv
// Shared types and constants for the ECC operation sequencer: opcodes, FSM states
// and the result-buffer entry layout.
package ecc_acc_pkg;

    localparam int XLEN     = 64;
    localparam int ID_WIDTH = 4;

    localparam logic [2:0] F3_SETMOD = 3'b000;
    localparam logic [2:0] F3_ADD    = 3'b001;
    localparam logic [2:0] F3_SUB    = 3'b010;
    localparam logic [2:0] F3_MUL    = 3'b011;

    localparam logic [5:0] EXC_ILLEGAL = 6'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [4:0]          rd;
        logic [XLEN-1:0]     data;
        logic                we;
        logic                exc;
        logic [5:0]          exccode;
    } result_entry_t;

    // Arithmetic opcodes 001/010/011 map onto unit slots 0/1/2.
    function automatic logic [1:0] f3_unit_idx(input logic [2:0] f3);
        return 2'(f3 - 3'd1);
    endfunction

endpackage

// File: rtl/ecc_op_sequencer_if.sv
// Core-facing issue and result handshake bundle of the ECC operation sequencer.
interface ecc_op_sequencer_if #(
    parameter int XLEN     = 64,
    parameter int ID_WIDTH = 4
) ();

    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [ID_WIDTH-1:0] issue_id_i;
    logic [2:0]          issue_funct3_i;
    logic [4:0]          issue_rd_i;
    logic [XLEN-1:0]     issue_rs1_i;
    logic [XLEN-1:0]     issue_rs2_i;

    logic                result_valid_o;
    logic                result_ready_i;
    logic [ID_WIDTH-1:0] result_id_o;
    logic [4:0]          result_rd_o;
    logic [XLEN-1:0]     result_data_o;
    logic                result_we_o;
    logic                result_exc_o;
    logic [5:0]          result_exccode_o;

    modport master (
        output issue_valid_i, issue_id_i, issue_funct3_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
        input  issue_ready_o,
        input  result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o,
               result_exc_o, result_exccode_o,
        output result_ready_i
    );

    modport slave (
        input  issue_valid_i, issue_id_i, issue_funct3_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
        output issue_ready_o,
        output result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o,
               result_exc_o, result_exccode_o,
        input  result_ready_i
    );

endinterface

// File: rtl/ecc_result_fifo.sv
// In-order result buffer with registered storage; push and pop may coincide.
module ecc_result_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ecc_op_sequencer.sv
// Issue FSM for the ECC accelerator: holds the modulus, dispatches ADD/SUB/MUL to the
// external units under a timeout, and queues results toward the core.
//
//   state    | meaning
//   ST_IDLE  | ready for a new request (unless the result buffer is full)
//   ST_START | one-cycle start pulse to the selected unit
//   ST_BUSY  | waiting for the selected unit's done, timeout counting down
module ecc_op_sequencer
    import ecc_acc_pkg::*;
#(
    parameter int         XLEN            = ecc_acc_pkg::XLEN,
    parameter int         ID_WIDTH        = ecc_acc_pkg::ID_WIDTH,
    parameter int         RES_DEPTH       = 2,
    parameter int         TIMEOUT_CYCLES  = 1024,
    parameter logic [5:0] TIMEOUT_EXCCODE = 6'd24
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    ecc_op_sequencer_if.slave core,
    output logic [2:0]        unit_start_o,
    output logic [XLEN-1:0]   unit_a_o,
    output logic [XLEN-1:0]   unit_b_o,
    output logic [XLEN-1:0]   modulus_o,
    input  logic [2:0]        unit_done_i,
    input  logic [3*XLEN-1:0] unit_result_i
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);

    state_e              state;
    logic                modulus_valid;
    logic [1:0]          sel_idx;
    logic [ID_WIDTH-1:0] op_id;
    logic [4:0]          op_rd;
    logic [TMO_W-1:0]    tmo_cnt;

    logic                accept;
    logic                is_arith;
    logic                done_sel;
    logic                tmo_hit;
    logic [XLEN-1:0]     unit_data;
    logic                buf_full;
    logic                buf_empty;
    logic                push;
    result_entry_t       push_entry;
    result_entry_t       head;

    assign core.issue_ready_o = rst_ni && (state == ST_IDLE) && !buf_full;
    assign accept    = core.issue_valid_i && core.issue_ready_o;
    assign is_arith  = (core.issue_funct3_i == F3_ADD) || (core.issue_funct3_i == F3_SUB) ||
                       (core.issue_funct3_i == F3_MUL);
    assign done_sel  = unit_done_i[sel_idx];
    assign unit_data = unit_result_i[sel_idx*XLEN +: XLEN];
    // Down-counter loaded in START; terminal count 1 means the last allowed BUSY cycle.
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_W'(1));

    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (state == ST_BUSY) begin
            push_entry.id = op_id;
            push_entry.rd = op_rd;
            if (done_sel) begin
                push            = 1'b1;
                push_entry.data = unit_data;
                push_entry.we   = 1'b1;
            end else if (tmo_hit) begin
                push               = 1'b1;
                push_entry.exc     = 1'b1;
                push_entry.exccode = TIMEOUT_EXCCODE;
            end
        end else if (accept) begin
            push_entry.id = core.issue_id_i;
            if (core.issue_funct3_i == F3_SETMOD) begin
                push = 1'b1;
            end else if (!(is_arith && modulus_valid)) begin
                push               = 1'b1;
                push_entry.rd      = core.issue_rd_i;
                push_entry.exc     = 1'b1;
                push_entry.exccode = EXC_ILLEGAL;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= ST_IDLE;
            modulus_o     <= '0;
            modulus_valid <= 1'b0;
            unit_start_o  <= '0;
            unit_a_o      <= '0;
            unit_b_o      <= '0;
            sel_idx       <= '0;
            op_id         <= '0;
            op_rd         <= '0;
            tmo_cnt       <= '0;
        end else begin
            unit_start_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (core.issue_funct3_i == F3_SETMOD) begin
                            modulus_o     <= core.issue_rs1_i;
                            modulus_valid <= 1'b1;
                        end else if (is_arith && modulus_valid) begin
                            unit_a_o     <= core.issue_rs1_i;
                            unit_b_o     <= core.issue_rs2_i;
                            sel_idx      <= f3_unit_idx(core.issue_funct3_i);
                            op_id        <= core.issue_id_i;
                            op_rd        <= core.issue_rd_i;
                            unit_start_o <= 3'b001 << f3_unit_idx(core.issue_funct3_i);
                            state        <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    tmo_cnt <= TMO_LOAD;
                    state   <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (done_sel || tmo_hit) begin
                        state <= ST_IDLE;
                    end else if (tmo_cnt != '0) begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ecc_result_fifo #(
        .DEPTH   (RES_DEPTH),
        .entry_t (result_entry_t)
    ) u_result_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (push),
        .push_data (push_entry),
        .pop       (core.result_ready_i),
        .full      (buf_full),
        .empty     (buf_empty),
        .head      (head)
    );

    assign core.result_valid_o   = !buf_empty;
    assign core.result_id_o      = head.id;
    assign core.result_rd_o      = head.rd;
    assign core.result_data_o    = head.data;
    assign core.result_we_o      = head.we;
    assign core.result_exc_o     = head.exc;
    assign core.result_exccode_o = head.exccode;

endmodule

// File: tb/tb_ecc_op_sequencer.sv
// Scoreboard bench for ecc_op_sequencer: issuer + modular-arithmetic unit emulator feed
// expectations, an independent result monitor pops and compares.
module tb_ecc_op_sequencer;

    localparam int XLEN = 64;
    localparam int IDW  = 4;
    localparam int TMO  = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [2:0]        unit_start_o;
    logic [XLEN-1:0]   unit_a_o;
    logic [XLEN-1:0]   unit_b_o;
    logic [XLEN-1:0]   modulus_o;
    logic [2:0]        unit_done_i;
    logic [3*XLEN-1:0] unit_result_i;

    always #5 clk_i = ~clk_i;

    ecc_op_sequencer_if #(.XLEN(XLEN), .ID_WIDTH(IDW)) core ();

    ecc_op_sequencer #(
        .XLEN            (XLEN),
        .ID_WIDTH        (IDW),
        .RES_DEPTH       (2),
        .TIMEOUT_CYCLES  (TMO),
        .TIMEOUT_EXCCODE (6'd24)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .core          (core),
        .unit_start_o  (unit_start_o),
        .unit_a_o      (unit_a_o),
        .unit_b_o      (unit_b_o),
        .modulus_o     (modulus_o),
        .unit_done_i   (unit_done_i),
        .unit_result_i (unit_result_i)
    );

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        we;
        logic        exc;
        logic [5:0]  code;
    } exp_t;

    typedef struct {
        logic [2:0]  oh;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] m;
        int          n;
    } start_t;

    exp_t   exp_q[$];
    start_t start_q[$];

    int vectors = 0;
    int miscompares = 0;
    int ready_mode = 1;   // 0 hold low, 1 hold high, 2 random

    logic [63:0] m_mod = '0;
    bit          m_mod_valid = 1'b0;

    function void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] mod_op(input logic [2:0] f3, input logic [63:0] a,
                                           input logic [63:0] b, input logic [63:0] m);
        logic [127:0] r;
        logic [127:0] mm;
        mm = {64'd0, m};
        case (f3)
            3'd1:    r = ({64'd0, a} + {64'd0, b}) % mm;
            3'd2:    r = (({64'd0, a} % mm) + mm - ({64'd0, b} % mm)) % mm;
            default: r = ({64'd0, a} * {64'd0, b}) % mm;
        endcase
        return r[63:0];
    endfunction

    // Reference model: what the core should eventually see for an accepted request.
    task automatic model_accept(input logic [3:0] id, input logic [2:0] f3, input logic [4:0] rd,
                                input logic [63:0] a, input logic [63:0] b, input int n);
        exp_t e;
        e = '{id: id, rd: rd, data: 64'd0, we: 1'b0, exc: 1'b1, code: 6'd2};
        if (f3 == 3'd0) begin
            m_mod       = a;
            m_mod_valid = 1'b1;
            e.rd  = 5'd0;
            e.exc = 1'b0;
            e.code = 6'd0;
        end else if (f3 <= 3'd3 && m_mod_valid) begin
            start_q.push_back('{oh: 3'b001 << (f3 - 3'd1), a: a, b: b, m: m_mod, n: n});
            if (n <= TMO) begin
                e.data = mod_op(f3, a, b, m_mod);
                e.we   = 1'b1;
                e.exc  = 1'b0;
                e.code = 6'd0;
            end else begin
                e.code = 6'd24;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic do_issue(input logic [3:0] id, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [63:0] a, input logic [63:0] b, input int n);
        int waited = 0;
        @(negedge clk_i);
        core.issue_valid_i  = 1'b1;
        core.issue_id_i     = id;
        core.issue_funct3_i = f3;
        core.issue_rd_i     = rd;
        core.issue_rs1_i    = a;
        core.issue_rs2_i    = b;
        while (!core.issue_ready_o && waited < 200) begin
            @(negedge clk_i);
            waited++;
        end
        if (!core.issue_ready_o) begin
            check("issue_accept_timeout", {63'd0, core.issue_ready_o}, 64'd1);
            core.issue_valid_i = 1'b0;
            return;
        end
        model_accept(id, f3, rd, a, b, n);
        @(negedge clk_i);
        core.issue_valid_i = 1'b0;
        if (f3 == 3'd0) check("modulus_after_setmod", modulus_o, m_mod);
    endtask

    // Cycles from the START-cycle negedge until issue_ready_o returns high.
    task automatic lat_check(input int exp_lat);
        int w = 0;
        while (!core.issue_ready_o && w < 100) begin
            @(negedge clk_i);
            w++;
        end
        check("ready_latency", 64'(w), 64'(exp_lat));
        check("valid_with_ready", {63'd0, core.result_valid_o}, 64'd1);
    endtask

    // Arithmetic unit emulator: answers the selected unit after n BUSY cycles, sprays noise.
    start_t      cur;
    bit          emu_active = 1'b0;
    int          emu_cnt = 0;
    int          emu_idx = 0;
    logic [63:0] emu_res = '0;

    initial begin
        unit_done_i   = '0;
        unit_result_i = '0;
        forever begin
            int keep;
            @(negedge clk_i);
            unit_done_i = '0;
            keep = emu_active ? emu_idx : -1;
            if (emu_active) begin
                emu_cnt++;
                if (emu_cnt == cur.n && cur.n <= TMO) begin
                    unit_done_i[emu_idx] = 1'b1;
                    unit_result_i[emu_idx*64 +: 64] = emu_res;
                    emu_active = 1'b0;
                end else if (emu_cnt == TMO + 1) begin
                    unit_done_i[emu_idx] = 1'b1;
                    unit_result_i[emu_idx*64 +: 64] = {$urandom, $urandom};
                    emu_active = 1'b0;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (k != keep && $urandom_range(3) == 0) begin
                    unit_done_i[k] = 1'b1;
                    unit_result_i[k*64 +: 64] = {$urandom, $urandom};
                end
            end
            if (unit_start_o != 3'b000) begin
                if (start_q.size() == 0) begin
                    check("unexpected_start", {61'd0, unit_start_o}, 64'd0);
                end else begin
                    cur = start_q.pop_front();
                    check("start_onehot", {61'd0, unit_start_o}, {61'd0, cur.oh});
                    check("unit_a", unit_a_o, cur.a);
                    check("unit_b", unit_b_o, cur.b);
                    check("unit_modulus", modulus_o, cur.m);
                    emu_idx    = (cur.oh == 3'b001) ? 0 : (cur.oh == 3'b010) ? 1 : 2;
                    emu_res    = mod_op(3'(emu_idx + 1), unit_a_o, unit_b_o, modulus_o);
                    emu_cnt    = 0;
                    emu_active = 1'b1;
                end
            end
        end
    end

    // Result monitor: picks ready, then compares the head that will be consumed.
    initial begin
        core.result_ready_i = 1'b0;
        forever begin
            exp_t e;
            @(negedge clk_i);
            case (ready_mode)
                0:       core.result_ready_i = 1'b0;
                1:       core.result_ready_i = 1'b1;
                default: core.result_ready_i = 1'($urandom_range(1));
            endcase
            if (core.result_valid_o && core.result_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {63'd0, core.result_valid_o}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_id", 64'(core.result_id_o), 64'(e.id));
                    check("res_rd", 64'(core.result_rd_o), 64'(e.rd));
                    check("res_data", core.result_data_o, e.data);
                    check("res_we", 64'(core.result_we_o), 64'(e.we));
                    check("res_exc", 64'(core.result_exc_o), 64'(e.exc));
                    check("res_exccode", 64'(core.result_exccode_o), 64'(e.code));
                end
            end
        end
    end

    initial begin
        int w;
        logic [2:0] f3;
        int r;
        core.issue_valid_i  = 1'b0;
        core.issue_id_i     = '0;
        core.issue_funct3_i = '0;
        core.issue_rd_i     = '0;
        core.issue_rs1_i    = '0;
        core.issue_rs2_i    = '0;

        repeat (3) @(negedge clk_i);
        check("rst_issue_ready", {63'd0, core.issue_ready_o}, 64'd0);
        check("rst_result_valid", {63'd0, core.result_valid_o}, 64'd0);
        check("rst_modulus", modulus_o, 64'd0);
        check("rst_unit_start", {61'd0, unit_start_o}, 64'd0);
        check("rst_unit_a", unit_a_o, 64'd0);
        check("rst_unit_b", unit_b_o, 64'd0);
        check("rst_result_id", 64'(core.result_id_o), 64'd0);
        check("rst_result_data", core.result_data_o, 64'd0);
        check("rst_result_exc", 64'(core.result_exc_o), 64'd0);
        rst_ni = 1'b1;
        #1;
        check("ready_after_release", {63'd0, core.issue_ready_o}, 64'd1);

        do_issue(4'd3, 3'b001, 5'd7, 64'd5, 64'd7, 1);
        do_issue(4'd4, 3'b101, 5'd8, 64'd1, 64'd2, 1);
        do_issue(4'd1, 3'b000, 5'd0, 64'h61, 64'd0, 0);
        do_issue(4'd2, 3'b001, 5'd9, 64'd5, 64'd7, 4);
        lat_check(5);
        do_issue(4'd5, 3'b011, 5'd3, 64'd40, 64'd50, 9);
        lat_check(TMO + 1);
        do_issue(4'd6, 3'b010, 5'd4, 64'd3, 64'd10, TMO);
        lat_check(TMO + 1);

        repeat (3) @(negedge clk_i);
        #2 ready_mode = 0;
        do_issue(4'd7, 3'b000, 5'd0, 64'h1234567, 64'd0, 0);
        do_issue(4'd8, 3'b000, 5'd0, 64'h89abcdef, 64'd0, 0);
        check("full_issue_ready", {63'd0, core.issue_ready_o}, 64'd0);
        check("full_head_id", 64'(core.result_id_o), 64'd7);
        repeat (2) @(negedge clk_i);
        check("full_hold_ready", {63'd0, core.issue_ready_o}, 64'd0);
        check("full_head_stable", 64'(core.result_id_o), 64'd7);
        #2 ready_mode = 1;
        @(negedge clk_i);
        #2 ready_mode = 0;
        @(negedge clk_i);
        #2;
        check("ready_after_pop", {63'd0, core.issue_ready_o}, 64'd1);
        check("head_after_pop", 64'(core.result_id_o), 64'd8);
        do_issue(4'd9, 3'b000, 5'd0, 64'h77, 64'd0, 0);
        #2 ready_mode = 2;

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(9);
            if (r < 2)      f3 = 3'd0;
            else if (r < 8) f3 = 3'(1 + (r % 3));
            else            f3 = 3'(4 + $urandom_range(3));
            do_issue(4'($urandom), f3, 5'($urandom), (f3 == 3'd0) ? ({$urandom, $urandom} | 64'd1)
                     : {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(1, 10));
        end

        #2 ready_mode = 1;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(negedge clk_i);
            w++;
        end
        repeat (12) @(negedge clk_i);
        do_issue(4'd10, 3'b011, 5'd1, 64'd11, 64'd13, 5);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b0;
        exp_q.delete();
        m_mod = '0;
        m_mod_valid = 1'b0;
        #1;
        check("midop_rst_ready", {63'd0, core.issue_ready_o}, 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            #2;
            check("post_rst_no_result", {63'd0, core.result_valid_o}, 64'd0);
        end
        check("post_rst_modulus", modulus_o, 64'd0);
        do_issue(4'd11, 3'b001, 5'd2, 64'd1, 64'd2, 1);
        do_issue(4'd12, 3'b000, 5'd0, 64'hfffffffffffffffb, 64'd0, 0);
        do_issue(4'd13, 3'b011, 5'd6, 64'hfedcba9876543210, 64'h0123456789abcdef, 2);

        #2 ready_mode = 2;
        w = 0;
        while ((exp_q.size() != 0 || start_q.size() != 0) && w < 500) begin
            @(negedge clk_i);
            w++;
        end
        check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        check("start_queue_drained", 64'(start_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
